// File: rtl/nn_pkg.sv
// Shared types, saturating fixed-point helpers and weight-ROM layout constants
// for the two-layer MLP inference engine.
package nn_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_L1,
        S_L1_DRAIN,
        S_L2,
        S_L2_DRAIN,
        S_ARGMAX,
        S_DONE
    } nn_state_e;

    // Clamp a full-precision value into a signed word of the given width.
    function automatic longint sat_clamp(input longint x, input int unsigned width);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (width - 1)) - longint'(1);
        lo = -hi - longint'(1);
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    function automatic longint sat_add(input longint a, input longint b, input int unsigned width);
        return sat_clamp(a + b, width);
    endfunction

    function automatic longint fxmul(input longint a, input longint b,
                                     input int unsigned width, input int unsigned frac);
        return sat_clamp((a * b) >>> frac, width);
    endfunction

    // Layer-1 occupies rows 0..N_IN (last row = biases); layer 2 follows at B2.
    function automatic int unsigned nn_t1(input int unsigned n_in, input int unsigned n_hid);
        return (n_in + 1) * n_hid;
    endfunction

    function automatic int unsigned nn_b2(input int unsigned n_in, input int unsigned n_hid);
        return (n_in + 1) * n_hid;
    endfunction

    function automatic int unsigned nn_t2(input int unsigned n_hid, input int unsigned n_out);
        return (n_hid + 1) * n_out;
    endfunction

endpackage

// File: rtl/nn_fxp_sat_mac.sv
// Bank of saturating accumulators updated one entry per cycle; the addend is
// either w directly (bypass) or the saturated fixed-point product a*w.
module nn_fxp_sat_mac
    import nn_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned FRAC  = 8,
    parameter int unsigned N_ACC = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    bypass,
    input  logic                    relu,
    input  logic [SEL_W-1:0]        idx,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] w,
    output logic signed [WIDTH-1:0] acc [N_ACC]
);

    logic signed [WIDTH-1:0] term;
    logic signed [WIDTH-1:0] acc_next [N_ACC];

    // ReLU is applied after the final update so it sees the completed sum.
    always_comb begin
        term = bypass ? w : WIDTH'(fxmul(longint'(a), longint'(w), WIDTH, FRAC));
        for (int k = 0; k < N_ACC; k++) begin
            acc_next[k] = acc[k];
            if (en && (idx == SEL_W'(k))) begin
                acc_next[k] = WIDTH'(sat_add(longint'(acc[k]), longint'(term), WIDTH));
            end
            if (relu && acc_next[k][WIDTH-1]) begin
                acc_next[k] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_ACC; k++) acc[k] <= '0;
        end else if (clr) begin
            for (int k = 0; k < N_ACC; k++) acc[k] <= '0;
        end else begin
            for (int k = 0; k < N_ACC; k++) acc[k] <= acc_next[k];
        end
    end

endmodule

// File: rtl/nn_mlp_engine.sv
// Two-layer binary-pixel MLP classifier: pixel capture, layer-1 with ReLU,
// layer-2 scores and sequential argmax, sharing one synchronous weight ROM.
module nn_mlp_engine
    import nn_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned FRAC   = 8,
    parameter int unsigned N_IN   = 784,
    parameter int unsigned N_HID  = 64,
    parameter int unsigned N_OUT  = 10,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              abort,
    input  logic              pix_valid,
    input  logic              pix_data,
    input  logic              pix_last,
    output logic              pix_ready,
    output logic [ADDR_W-1:0] w_addr,
    output logic              w_en,
    input  logic [WIDTH-1:0]  w_rdata,
    output logic              busy,
    output logic [IDX_W-1:0]  result,
    output logic [WIDTH-1:0]  result_score,
    output logic              result_valid
);

    localparam int unsigned T1    = nn_t1(N_IN, N_HID);
    localparam int unsigned B2    = nn_b2(N_IN, N_HID);
    localparam int unsigned T2    = nn_t2(N_HID, N_OUT);
    localparam int unsigned PIX_W = $clog2(N_IN);
    localparam int unsigned ROW_W = $clog2(((N_IN > N_HID) ? N_IN : N_HID) + 1);
    localparam int unsigned COL_W = $clog2((N_HID > N_OUT) ? N_HID : N_OUT);
    localparam int unsigned HID_W = $clog2(N_HID);
    localparam int unsigned OUT_W = $clog2(N_OUT);

    nn_state_e state, state_next;

    logic                    accept, img_end, issue_last, col_last;
    logic [PIX_W-1:0]        pix_cnt;
    logic [N_IN-1:0]         pix_buf;
    logic [ROW_W-1:0]        row, pipe_row;
    logic [COL_W-1:0]        col, pipe_col;
    logic                    pipe_valid, pipe_l2, pipe_bias;
    logic [OUT_W-1:0]        arg_idx, best_idx;
    logic signed [WIDTH-1:0] best_score;
    logic                    pix_bit;
    logic signed [WIDTH-1:0] hid_term;
    logic signed [WIDTH-1:0] hid_acc [N_HID];
    logic signed [WIDTH-1:0] out_acc [N_OUT];

    assign pix_ready = (state == S_IDLE) || (state == S_LOAD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state and per-cycle control strobes; abort overrides everything.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        img_end    = 1'b0;
        issue_last = 1'b0;
        col_last   = (state == S_L1) ? (col == COL_W'(N_HID - 1)) : (col == COL_W'(N_OUT - 1));
        case (state)
            S_IDLE, S_LOAD: begin
                accept  = pix_valid;
                img_end = pix_valid && (pix_last || (pix_cnt == PIX_W'(N_IN - 1)));
                if (img_end)        state_next = S_L1;
                else if (pix_valid) state_next = S_LOAD;
            end
            S_L1: begin
                issue_last = (w_addr == ADDR_W'(T1 - 1));
                if (issue_last) state_next = S_L1_DRAIN;
            end
            S_L1_DRAIN: state_next = S_L2;
            S_L2: begin
                issue_last = (w_addr == ADDR_W'(B2 + T2 - 1));
                if (issue_last) state_next = S_L2_DRAIN;
            end
            S_L2_DRAIN: state_next = S_ARGMAX;
            S_ARGMAX:   if (arg_idx == OUT_W'(N_OUT - 1)) state_next = S_DONE;
            S_DONE:     state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
        if (abort) begin
            state_next = S_IDLE;
            accept     = 1'b0;
            img_end    = 1'b0;
        end
    end

    // Datapath registers: capture, address issue, ROM-latency pipeline, argmax.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_addr       <= '0;
            w_en         <= 1'b0;
            busy         <= 1'b0;
            result       <= '0;
            result_score <= '0;
            result_valid <= 1'b0;
            pix_cnt      <= '0;
            pix_buf      <= '0;
            row          <= '0;
            col          <= '0;
            pipe_valid   <= 1'b0;
            pipe_l2      <= 1'b0;
            pipe_bias    <= 1'b0;
            pipe_row     <= '0;
            pipe_col     <= '0;
            arg_idx      <= '0;
            best_idx     <= '0;
            best_score   <= '0;
        end else begin
            result_valid <= 1'b0;
            busy         <= (state_next != S_IDLE) && (state_next != S_LOAD);
            pipe_valid   <= w_en && !abort;
            pipe_l2      <= (state == S_L2);
            pipe_bias    <= (state == S_L2) ? (row == ROW_W'(N_HID)) : (row == ROW_W'(N_IN));
            pipe_row     <= row;
            pipe_col     <= col;
            if (abort) begin
                w_en    <= 1'b0;
                pix_cnt <= '0;
                pix_buf <= '0;
            end else begin
                case (state)
                    S_IDLE, S_LOAD: begin
                        if (accept) begin
                            pix_buf[pix_cnt] <= pix_data;
                            pix_cnt          <= img_end ? '0 : pix_cnt + PIX_W'(1);
                            if (img_end) begin
                                w_addr <= '0;
                                w_en   <= 1'b1;
                                row    <= '0;
                                col    <= '0;
                            end
                        end
                    end
                    S_L1, S_L2: begin
                        if (issue_last) begin
                            w_en <= 1'b0;
                        end else begin
                            w_addr <= w_addr + ADDR_W'(1);
                            if (col_last) begin
                                col <= '0;
                                row <= row + ROW_W'(1);
                            end else begin
                                col <= col + COL_W'(1);
                            end
                        end
                    end
                    S_L1_DRAIN: begin
                        w_addr <= ADDR_W'(B2);
                        w_en   <= 1'b1;
                        row    <= '0;
                        col    <= '0;
                    end
                    S_L2_DRAIN: arg_idx <= '0;
                    S_ARGMAX: begin
                        arg_idx <= arg_idx + OUT_W'(1);
                        if ((arg_idx == '0) || (out_acc[arg_idx] > best_score)) begin
                            best_score <= out_acc[arg_idx];
                            best_idx   <= arg_idx;
                        end
                    end
                    S_DONE: begin
                        result       <= IDX_W'(best_idx);
                        result_score <= best_score;
                        result_valid <= 1'b1;
                        pix_buf      <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        pix_bit  = pipe_bias || pix_buf[PIX_W'(pipe_row)];
        hid_term = pix_bit ? w_rdata : '0;
    end

    nn_fxp_sat_mac #(
        .WIDTH(WIDTH), .FRAC(FRAC), .N_ACC(N_HID), .SEL_W(HID_W)
    ) u_hid_mac (
        .clk    (clk),
        .rst    (rst),
        .clr    (img_end),
        .en     (pipe_valid && !pipe_l2),
        .bypass (1'b1),
        .relu   (state == S_L1_DRAIN),
        .idx    (HID_W'(pipe_col)),
        .a      ('0),
        .w      (hid_term),
        .acc    (hid_acc)
    );

    nn_fxp_sat_mac #(
        .WIDTH(WIDTH), .FRAC(FRAC), .N_ACC(N_OUT), .SEL_W(OUT_W)
    ) u_out_mac (
        .clk    (clk),
        .rst    (rst),
        .clr    (img_end),
        .en     (pipe_valid && pipe_l2),
        .bypass (pipe_bias),
        .relu   (1'b0),
        .idx    (OUT_W'(pipe_col)),
        .a      (hid_acc[HID_W'(pipe_row)]),
        .w      (w_rdata),
        .acc    (out_acc)
    );

endmodule

// File: tb/tb_nn_mlp_engine.sv
// Bench for nn_mlp_engine with a 4-2-3 network: directed cases plus randomized
// images/weights checked against a plain-arithmetic reference network.
module tb_nn_mlp_engine;

    localparam int NI    = 4;
    localparam int NH    = 2;
    localparam int NO    = 3;
    localparam int FR    = 8;
    localparam int B2    = (NI + 1) * NH;
    localparam int ROM_N = B2 + (NH + 1) * NO;
    localparam int LAT   = 25;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        abort = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_data = 1'b0;
    logic        pix_last = 1'b0;
    logic        pix_ready;
    logic [15:0] w_addr;
    logic        w_en;
    logic [15:0] w_rdata = '0;
    logic        busy;
    logic [3:0]  result;
    logic [15:0] result_score;
    logic        result_valid;

    logic [15:0] rom [ROM_N];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0 = 0;

    nn_mlp_engine #(
        .WIDTH(16), .FRAC(FR), .N_IN(NI), .N_HID(NH), .N_OUT(NO), .ADDR_W(16), .IDX_W(4)
    ) dut (
        .clk(clk), .rst(rst), .abort(abort),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_last(pix_last), .pix_ready(pix_ready),
        .w_addr(w_addr), .w_en(w_en), .w_rdata(w_rdata),
        .busy(busy), .result(result), .result_score(result_score), .result_valid(result_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROM: one cycle read latency.
    always @(posedge clk) begin
        if (w_en) w_rdata <= (int'(w_addr) < ROM_N) ? rom[w_addr] : 16'hxxxx;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint clamp16(input longint x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic longint sw(input int a);
        return longint'($signed(rom[a]));
    endfunction

    // Reference network straight from the weight-layout and arithmetic rules.
    task automatic model(input logic [3:0] px, output logic [3:0] eidx, output logic [15:0] escore);
        longint hid [NH];
        longint outv [NO];
        longint acc;
        int best;
        for (int h = 0; h < NH; h++) begin
            acc = 0;
            for (int i = 0; i < NI; i++) if (px[i]) acc = clamp16(acc + sw(i * NH + h));
            acc = clamp16(acc + sw(NI * NH + h));
            hid[h] = (acc < 0) ? 0 : acc;
        end
        for (int o = 0; o < NO; o++) begin
            acc = 0;
            for (int h = 0; h < NH; h++)
                acc = clamp16(acc + clamp16((hid[h] * sw(B2 + h * NO + o)) >>> FR));
            acc = clamp16(acc + sw(B2 + NH * NO + o));
            outv[o] = acc;
        end
        best = 0;
        for (int o = 1; o < NO; o++) if (outv[o] > outv[best]) best = o;
        eidx   = 4'(best);
        escore = 16'(outv[best]);
    endtask

    task automatic clear_rom();
        for (int a = 0; a < ROM_N; a++) rom[a] = '0;
    endtask

    task automatic random_rom(input bit full);
        for (int a = 0; a < ROM_N; a++)
            rom[a] = full ? 16'($urandom) : 16'($urandom_range(0, 1023)) - 16'd512;
    endtask

    task automatic send_image(input logic [3:0] px, input int nb, input bit last_on_final);
        for (int k = 0; k < nb; k++) begin
            @(negedge clk);
            pix_valid = 1'b1;
            pix_data  = px[k];
            pix_last  = (k == nb - 1) && last_on_final;
        end
        @(posedge clk);
        #1;
        t0 = cyc;
        pix_valid = 1'b0;
        pix_data  = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [3:0] eidx, input logic [15:0] escore);
        int guard = 0;
        while (result_valid !== 1'b1 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk({tag, "_latency"}, 64'(cyc - t0), 64'(LAT));
        chk({tag, "_result"}, 64'(result), 64'(eidx));
        chk({tag, "_score"}, 64'(result_score), 64'(escore));
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 64'(result_valid), 64'(0));
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_w_addr"}, 64'(w_addr), 64'(0));
        chk({tag, "_w_en"}, 64'(w_en), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_result"}, 64'(result), 64'(0));
        chk({tag, "_score"}, 64'(result_score), 64'(0));
        chk({tag, "_valid"}, 64'(result_valid), 64'(0));
        chk({tag, "_pix_ready"}, 64'(pix_ready), 64'(1));
    endtask

    initial begin
        logic [3:0]  px;
        logic [3:0]  eidx;
        logic [15:0] escore;
        int nb;
        bit lst;
        int pulses;

        clear_rom();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;

        // Distinct L2 biases; pixels 1,0,1,1.
        rom[16] = 16'h0100; rom[17] = 16'h0300; rom[18] = 16'h0200;
        send_image(4'b1101, 4, 1'b1);
        chk("t1_busy", 64'(busy), 64'(1));
        chk("t1_pix_ready", 64'(pix_ready), 64'(0));
        wait_result("t1", 4'd1, 16'h0300);

        // Tied scores resolve to the lowest index.
        rom[17] = 16'h0100; rom[18] = 16'h0100;
        send_image(4'b0110, 4, 1'b1);
        wait_result("t2_tie", 4'd0, 16'h0100);

        // Hidden saturation; capture ends on the pixel count alone.
        clear_rom();
        rom[0] = 16'h7000; rom[2] = 16'h7000; rom[4] = 16'h7000; rom[6] = 16'h7000;
        rom[12] = 16'h0100;
        send_image(4'b1111, 4, 1'b0);
        wait_result("t3_sat", 4'd2, 16'h7FFF);

        // Abort on the fifth L1 cycle; old result must remain, no pulse.
        clear_rom();
        rom[16] = 16'h0100; rom[17] = 16'h0300; rom[18] = 16'h0200;
        send_image(4'b1101, 4, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_pix_ready", 64'(pix_ready), 64'(1));
        chk("abort_w_en", 64'(w_en), 64'(0));
        chk("abort_result_kept", 64'(result), 64'(2));
        chk("abort_score_kept", 64'(result_score), 64'(16'h7FFF));
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (result_valid) pulses++;
        end
        chk("abort_no_pulse", 64'(pulses), 64'(0));
        send_image(4'b1101, 4, 1'b1);
        wait_result("abort_next", 4'd1, 16'h0300);

        // ReLU clamps a negative hidden sum to zero.
        clear_rom();
        rom[8] = 16'hFF00; rom[11] = 16'h0100;
        send_image(4'b1011, 4, 1'b1);
        wait_result("t4_relu", 4'd0, 16'h0000);

        // Random networks and images; pixel beats offered while busy must be ignored.
        for (int it = 0; it < 6; it++) begin
            random_rom(it[0]);
            px  = 4'($urandom);
            nb  = $urandom_range(1, 4);
            lst = (nb < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int k = nb; k < NI; k++) px[k] = 1'b0;
            model(px, eidx, escore);
            send_image(px, nb, lst);
            repeat (3) begin
                @(negedge clk);
                pix_valid = 1'b1;
                pix_data  = 1'b1;
                pix_last  = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            pix_valid = 1'b0;
            pix_data  = 1'b0;
            pix_last  = 1'b0;
            wait_result($sformatf("rand%0d", it), eidx, escore);
        end

        // Reset in the middle of L2, then an image ending early on pixel 2.
        random_rom(1'b0);
        send_image(4'b1111, 4, 1'b1);
        repeat (13) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        chk_reset_values("midrst");
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < NI * NH; a++) rom[a] = 16'($urandom_range(256, 2048));
        model(4'b0011, eidx, escore);
        send_image(4'b1111, 2, 1'b1);
        wait_result("rst_next", eidx, escore);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nn_mlp_engine.md
Name: nn_mlp_engine

Overview:
- Parametrised two-layer MLP inference engine for binary-pixel digit images: input → hidden (ReLU) → output scores → argmax.
- Next generation of the fixed 784→64→10 classifier, adding:
  - start-on-load pixel stream handshake;
  - correct 1-cycle weight-ROM latency handling;
  - saturating fixed-point arithmetic;
  - abort;
  - a one-cycle result_valid pulse plus the winning score.
- Sits between the image capture stream and the 7-segment/LED display logic; shares one external synchronous weight ROM.

Parameters:
- WIDTH, 16, signed fixed-point word width (two's complement).
- FRAC, 8, fractional bits; FRAC < WIDTH-1.
- N_IN, 784, number of input pixels (1 bit each).
- N_HID, 64, number of hidden neurons.
- N_OUT, 10, number of output classes; N_OUT >= 2.
- ADDR_W, 16, weight ROM address width; must hold (N_IN+1)*N_HID + (N_HID+1)*N_OUT.
- IDX_W, 4, result index width; must satisfy 2**IDX_W >= N_OUT.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- abort  in  1  synchronous abort; returns the engine to IDLE, no result produced.
- pix_valid  in  1  pixel beat valid.
- pix_data  in  1  pixel value (1 = ink).
- pix_last  in  1  marks the final pixel of an image.
- pix_ready  out  1  high in IDLE/LOAD only.
- w_addr  out  ADDR_W  weight ROM address.
- w_en  out  1  ROM read enable.
- w_rdata  in  WIDTH  ROM data; valid on the cycle after w_en.
- busy  out  1  high in every state except IDLE/LOAD.
- result  out  IDX_W  predicted class; held until the next result.
- result_score  out  WIDTH  output score of the winning class.
- result_valid  out  1  one-cycle pulse when result is updated.

Behaviour:
- Reset values:
  - state=IDLE;
  - w_addr=0, w_en=0, busy=0, result=0, result_score=0, result_valid=0;
  - all accumulators and the pixel buffer cleared;
  - pix_ready=1 (combinational from state).
- Weight layout, offsets from address 0:
  - L1 weight(i,h) at i*N_HID+h;
  - L1 bias(h) at N_IN*N_HID+h;
  - L2 base B2 = (N_IN+1)*N_HID;
  - L2 weight(h,o) at B2+h*N_OUT+o;
  - L2 bias(o) at B2+N_HID*N_OUT+o.
- States: IDLE, LOAD, L1, L1_DRAIN, L2, L2_DRAIN, ARGMAX, DONE.
- IDLE/LOAD (pixel capture):
  - A beat with pix_valid&pix_ready stores pix_data at pixel counter p, then p++; IDLE→LOAD on the first beat.
  - pix_last, or p reaching N_IN-1, ends the image: next state L1.
  - Early pix_last zero-fills the remaining pixels.
  - Beats beyond N_IN are impossible because capture ends at N_IN-1.
- L1:
  - Issue addresses 0..T1-1 sequentially, T1=(N_IN+1)*N_HID, with w_en=1.
  - The index pipeline is registered one cycle to align with w_rdata.
  - Accumulation: hid[h] = sat_add(hid[h], pixel ? w : 0); bias rows are always added.
- L1_DRAIN (1 cycle):
  - Consume the last datum.
  - Apply ReLU: negative values → 0.
- L2:
  - Issue T2=(N_HID+1)*N_OUT addresses.
  - Accumulation: out[o] = sat_add(out[o], fxmul(hid[h], w)); bias rows add w directly.
- L2_DRAIN (1 cycle): consume the last datum; w_en=0.
- ARGMAX (N_OUT cycles):
  - Sequential signed comparison; an index replaces the current best only if strictly greater.
  - Ties resolve to the lowest index.
- DONE (1 cycle):
  - result, result_score and result_valid=1 are registered.
  - Next state is IDLE; accumulators are cleared on entry to L1.
- Latency: result_valid rises exactly T1+T2+N_OUT+3 cycles after the edge accepting the final pixel.
- Arithmetic:
  - sat_add: full-precision sum, clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - fxmul: 2*WIDTH signed product, arithmetic shift right FRAC, then clamped the same way.
- abort:
  - Highest priority after rst, in any state.
  - Next cycle: state=IDLE, w_en=0, busy=0, p=0.
  - No result_valid; result and result_score keep their old values.
- pix_valid while busy is ignored, with no storage.

Decomposition:
- Package nn_pkg holds:
  - the state enumeration;
  - the sat_add and fxmul functions, parametrised by WIDTH/FRAC;
  - address-base helper constants B2, T1, T2.
- One sub-module: nn_fxp_sat_mac.
  - Registered multiply-accumulate with a bypass-multiply mode, used for both layers.

Test Plan (N_IN=4, N_HID=2, N_OUT=3, WIDTH=16, FRAC=8 ⇒ T1=10, T2=9, latency 25):
- All weights 0, L2 biases {0x0100,0x0300,0x0200}, pixels 1,0,1,1 (last on 4th) → result_valid exactly 25 cycles after the last beat; result=1, result_score=0x0300; pulse lasts 1 cycle.
- All weights 0, L2 biases all 0x0100 → result=0 (tie, lowest index), score 0x0100.
- Pixels all 1, L1 weights for h0 = 0x7000, L2 weight(h0,o2)=0x0100, other weights/biases 0 → hid0 saturates to 0x7FFF; result=2, score=0x7FFF.
- L1 bias h0=0xFF00, L2 weight(h0,o1)=0x0100, rest 0 → ReLU zeroes hid0; all scores 0, result=0.
- abort asserted on cycle 5 of L1 → busy=0 next cycle, pix_ready=1, no result_valid; a following image completes normally with a fresh result.
- rst asserted mid-L2, then a pix_last asserted early on the 2nd pixel → all outputs at reset values; the next image zero-fills pixels 2..3 and produces a result with standard latency.
